fetch_resp_unit: RTL and testbench
==================================

// Module: fetch_resp_unit
// PURPOSE
// - Tile-side responder for remote fetch requests issued by other tiles' load units.
// - Buffers incoming requests in a FIFO, reads the local memory, and returns one response per request.
// - Each response carries the requester's coordinates and port id; responses leave in request order.
// - Sits between the inter-tile request network and the local memory read port.
// PARAMETERS
// - X_COORD      1   this tile's x coordinate
// - Y_COORD      1   this tile's y coordinate
// - DATA_WIDTH   32  memory word / response data width
// - FIFO_DEPTH   4   request FIFO entries (power of 2, >=2)
// - MEM_LATENCY  1   cycles from mem_rd_en to valid mem_rd_data (>=1)
// PORTS
// - clk          in   1                     clock
// - rst          in   1                     asynchronous active-high reset
// - req_vld      in   1                     request valid
// - req_rdy      out  1                     request ready (FIFO not full)
// - req_addr     in   ADDR_LENGTH           global address {x,y,...,local}
// - req_src_x    in   COORD_LENGTH          requester x
// - req_src_y    in   COORD_LENGTH          requester y
// - req_id       in   1                     requester port (0=addr1, 1=addr2)
// - mem_rd_en    out  1                     local memory read strobe
// - mem_rd_addr  out  $clog2(MEM_HEIGHT)    req_addr[$clog2(MEM_HEIGHT)-1:0]
// - mem_rd_data  in   DATA_WIDTH            read data, valid MEM_LATENCY cycles after mem_rd_en
// - rsp_vld      out  1                     response valid
// - rsp_rdy      in   1                     response ready
// - rsp_data     out  DATA_WIDTH            read data
// - rsp_dst_x    out  COORD_LENGTH          = req_src_x of the served request
// - rsp_dst_y    out  COORD_LENGTH          = req_src_y of the served request
// - rsp_id       out  1                     = req_id of the served request
// - rsp_err      out  1                     address error flag (see CONFIGURATION)
// BEHAVIOUR
// - Reset: FIFO emptied, state IDLE; outputs reset to: req_rdy=1, mem_rd_en=0, mem_rd_addr=0, rsp_vld=0, rsp_data/dst/id/err=0.
// - Reset mid-operation: in-flight read is abandoned; mem_rd_data returning after reset is ignored.
// - Push: on req_vld&&req_rdy; req_rdy=!full, registered from count. A push to a full FIFO is impossible.
// - FSM IDLE: if FIFO non-empty, pop head into the working registers and go to RD.
//   A request pushed into an empty FIFO is not popped in the same cycle.
// - FSM RD: mem_rd_en=1 for exactly this cycle, mem_rd_addr=working local addr; load cnt=MEM_LATENCY-1; go to WAIT.
// - FSM WAIT: if cnt==0, capture mem_rd_data into rsp_data and go to RESP; otherwise decrement cnt.
// - FSM RESP: rsp_vld=1; all rsp_* fields are held stable until rsp_rdy.
//   On rsp_vld&&rsp_rdy with FIFO non-empty: pop and go to RD (skip IDLE); with FIFO empty: go to IDLE.
// - Latency (rsp_rdy=1): accept at cycle 0 -> rsp_vld at cycle MEM_LATENCY+3.
// - Throughput (rsp_rdy=1): one response every MEM_LATENCY+2 cycles.
// - One read outstanding at a time; strict FIFO order; no response dropped or duplicated.
// - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap; count is $clog2(FIFO_DEPTH)+1 bits.
// - Simultaneous push and pop is legal when the FIFO is neither full nor empty; count is unchanged.
// CONFIGURATION
// - Macro FETCH_RESP_ADDR_CHECK_EN.
// - Defined: at pop, req_addr coordinate fields (top 2*COORD_LENGTH bits) are compared with X_COORD/Y_COORD.
//   On mismatch: skip RD/WAIT, go directly to RESP with rsp_err=1, rsp_data=0, no mem_rd_en.
//   On match: normal flow with rsp_err=0.
// - Undefined: no comparison; every request is read from memory using its low address bits; rsp_err is constant 0.
// TESTING
// - Reset: assert rst asynchronously mid-cycle -> rsp_vld=0, mem_rd_en=0 immediately; req_rdy=1 after release.
// - Single request, MEM_LATENCY=1: local addr 5, src (2,3), id 1, memory returns 32'hDEADBEEF, accepted cycle 0
//   -> mem_rd_en/mem_rd_addr=5 at cycle 2; rsp_vld at cycle 4 with data DEADBEEF, dst (2,3), id 1.
// - Backpressure: rsp_rdy=0, push 6 requests -> 5 accepted (1 in service + 4 buffered), req_rdy=0 for the 6th;
//   rsp_rdy=1 -> 5 responses in order with data held stable while stalled.
// - Throughput: rsp_rdy=1, 4 back-to-back requests, MEM_LATENCY=2 -> rsp_vld pulses exactly 4 cycles apart.
// - Reset in WAIT: rst during WAIT -> no response for the in-flight request; next request is served normally.
// - Address check: request for tile (0,2) at tile (1,1): with macro -> rsp_err=1, data 0, no mem_rd_en;
//   without macro -> memory read occurs, rsp_err=0.

Source files
------------

// File: rtl/fetch_resp_unit.sv
// -----------------------------------------------------------------------------
// fetch_resp_unit
//
// Tile-side responder for remote fetch requests. Requests from the inter-tile
// network are buffered in a small FIFO. Each one is served in turn by a single
// read of the local memory, and the response is returned with the requester's
// coordinates and port id. Responses leave in the order the requests arrived.
// Only one memory read is outstanding at a time.
//
// Optional feature (macro FETCH_RESP_ADDR_CHECK_EN):
//   When the macro is defined, the coordinate field of each request address
//   (the top 2*COORD_LENGTH bits) is compared with this tile's X_COORD/Y_COORD
//   as the request is popped. A request for another tile skips the memory
//   read and is answered at once with rsp_err=1 and rsp_data=0. When the macro
//   is undefined, every request is read from memory using its low address
//   bits, and rsp_err is tied to 0.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_vld/req_rdy           request handshake (req_rdy = FIFO not full)
//   req_addr                  global address {x, y, ..., local}
//   req_src_x/req_src_y       requester coordinates
//   req_id                    requester port (0 = addr1, 1 = addr2)
//   mem_rd_en/mem_rd_addr     local memory read strobe and word address
//   mem_rd_data               read data, valid MEM_LATENCY cycles after strobe
//   rsp_vld/rsp_rdy           response handshake
//   rsp_data                  read data
//   rsp_dst_x/rsp_dst_y       requester coordinates of the served request
//   rsp_id                    requester port of the served request
//   rsp_err                   address error flag
// -----------------------------------------------------------------------------
module fetch_resp_unit #(
  parameter int X_COORD      = 1,
  parameter int Y_COORD      = 1,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int MEM_LATENCY  = 1,
  parameter int COORD_LENGTH = 4,
  parameter int MEM_HEIGHT   = 256,
  parameter int ADDR_LENGTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_vld,
  output logic                          req_rdy,
  input  logic [ADDR_LENGTH-1:0]        req_addr,
  input  logic [COORD_LENGTH-1:0]       req_src_x,
  input  logic [COORD_LENGTH-1:0]       req_src_y,
  input  logic                          req_id,
  output logic                          mem_rd_en,
  output logic [$clog2(MEM_HEIGHT)-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]         mem_rd_data,
  output logic                          rsp_vld,
  input  logic                          rsp_rdy,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [COORD_LENGTH-1:0]       rsp_dst_x,
  output logic [COORD_LENGTH-1:0]       rsp_dst_y,
  output logic                          rsp_id,
  output logic                          rsp_err
);

  localparam int LOCAL_W = $clog2(MEM_HEIGHT);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int LAT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t state;

  // Request FIFO storage (data only, no reset needed)
  logic [ADDR_LENGTH-1:0]  fifo_addr  [FIFO_DEPTH];
  logic [COORD_LENGTH-1:0] fifo_src_x [FIFO_DEPTH];
  logic [COORD_LENGTH-1:0] fifo_src_y [FIFO_DEPTH];
  logic                    fifo_id    [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  logic [ADDR_LENGTH-1:0]  head_addr;
  logic [COORD_LENGTH-1:0] head_src_x;
  logic [COORD_LENGTH-1:0] head_src_y;
  logic                    head_id;

  logic [LAT_W-1:0] lat_cnt;

  assign fifo_empty = (count == '0);
  assign push       = req_vld && req_rdy;

  // Pop only on the registered count, so a request written into an empty
  // FIFO is not visible to the FSM until the following cycle.
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) || (state == ST_RESP && rsp_vld && rsp_rdy));

  assign head_addr  = fifo_addr[rd_ptr];
  assign head_src_x = fifo_src_x[rd_ptr];
  assign head_src_y = fifo_src_y[rd_ptr];
  assign head_id    = fifo_id[rd_ptr];

  // Not every address bit reaches the datapath in every build.
  logic unused_head_bits;
  assign unused_head_bits = ^head_addr;

`ifdef FETCH_RESP_ADDR_CHECK_EN
  logic head_mismatch;
  assign head_mismatch =
    (head_addr[ADDR_LENGTH-1 -: COORD_LENGTH] != COORD_LENGTH'(X_COORD)) ||
    (head_addr[ADDR_LENGTH-COORD_LENGTH-1 -: COORD_LENGTH] != COORD_LENGTH'(Y_COORD));
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  // ---- FIFO write port ----
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= req_addr;
      fifo_src_x[wr_ptr] <= req_src_x;
      fifo_src_y[wr_ptr] <= req_src_y;
      fifo_id[wr_ptr]    <= req_id;
    end
  end

  // ---- FIFO pointers, occupancy and registered ready ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      req_rdy <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_nxt;
      req_rdy <= (count_nxt != CNT_W'(FIFO_DEPTH));
    end
  end

  // ---- Service FSM: pop -> read strobe -> wait latency -> hold response ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      lat_cnt     <= '0;
      rsp_vld     <= 1'b0;
      rsp_data    <= '0;
      rsp_dst_x   <= '0;
      rsp_dst_y   <= '0;
      rsp_id      <= 1'b0;
`ifdef FETCH_RESP_ADDR_CHECK_EN
      rsp_err     <= 1'b0;
`endif
    end else begin
      mem_rd_en <= 1'b0;

      case (state)
        ST_IDLE: begin
          // Popping is handled below.
        end
        ST_RD: begin
          lat_cnt <= LAT_W'(MEM_LATENCY - 1);
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt == '0) begin
            rsp_data <= mem_rd_data;
            rsp_vld  <= 1'b1;
            state    <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_rdy) begin
            rsp_vld <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A pop (from IDLE, or straight out of a completed RESP) loads the
      // working registers and overrides the transitions above.
      if (pop) begin
        rsp_dst_x <= head_src_x;
        rsp_dst_y <= head_src_y;
        rsp_id    <= head_id;
`ifdef FETCH_RESP_ADDR_CHECK_EN
        if (head_mismatch) begin
          rsp_err  <= 1'b1;
          rsp_data <= '0;
          rsp_vld  <= 1'b1;
          state    <= ST_RESP;
        end else begin
          rsp_err     <= 1'b0;
          mem_rd_en   <= 1'b1;
          mem_rd_addr <= head_addr[LOCAL_W-1:0];
          state       <= ST_RD;
        end
`else
        mem_rd_en   <= 1'b1;
        mem_rd_addr <= head_addr[LOCAL_W-1:0];
        state       <= ST_RD;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fetch_resp_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_resp_unit
//
// Directed bench for fetch_resp_unit. Instance u_dut uses MEM_LATENCY=1 and
// covers reset, single request, backpressure, reset mid-operation and the
// address check. Instance u_dut2 uses MEM_LATENCY=2 for the throughput case.
// Each memory model returns a poison word when no read was strobed, so a
// capture at the wrong cycle shows up as bad data.
// -----------------------------------------------------------------------------
module tb_fetch_resp_unit;

  localparam logic [31:0] POISON = 32'hBAD0_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        req_vld, req_rdy, req_id;
  logic [15:0] req_addr;
  logic [3:0]  req_src_x, req_src_y;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        rsp_vld, rsp_rdy, rsp_id, rsp_err;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_dst_x, rsp_dst_y;

  logic        req_vld_b, req_rdy_b, req_id_b;
  logic [15:0] req_addr_b;
  logic [3:0]  req_src_x_b, req_src_y_b;
  logic        mem_rd_en_b;
  logic [7:0]  mem_rd_addr_b;
  logic [31:0] mem_rd_data_b, mem_s1_b;
  logic        rsp_vld_b, rsp_rdy_b, rsp_id_b, rsp_err_b;
  logic [31:0] rsp_data_b;
  logic [3:0]  rsp_dst_x_b, rsp_dst_y_b;

  fetch_resp_unit #(.X_COORD(1), .Y_COORD(1), .DATA_WIDTH(32), .FIFO_DEPTH(4),
                    .MEM_LATENCY(1), .COORD_LENGTH(4), .MEM_HEIGHT(256),
                    .ADDR_LENGTH(16)) u_dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
    .req_src_x(req_src_x), .req_src_y(req_src_y), .req_id(req_id),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
    .rsp_dst_x(rsp_dst_x), .rsp_dst_y(rsp_dst_y), .rsp_id(rsp_id),
    .rsp_err(rsp_err)
  );

  fetch_resp_unit #(.X_COORD(1), .Y_COORD(1), .DATA_WIDTH(32), .FIFO_DEPTH(4),
                    .MEM_LATENCY(2), .COORD_LENGTH(4), .MEM_HEIGHT(256),
                    .ADDR_LENGTH(16)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_vld(req_vld_b), .req_rdy(req_rdy_b), .req_addr(req_addr_b),
    .req_src_x(req_src_x_b), .req_src_y(req_src_y_b), .req_id(req_id_b),
    .mem_rd_en(mem_rd_en_b), .mem_rd_addr(mem_rd_addr_b), .mem_rd_data(mem_rd_data_b),
    .rsp_vld(rsp_vld_b), .rsp_rdy(rsp_rdy_b), .rsp_data(rsp_data_b),
    .rsp_dst_x(rsp_dst_x_b), .rsp_dst_y(rsp_dst_y_b), .rsp_id(rsp_id_b),
    .rsp_err(rsp_err_b)
  );

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return (a == 8'd5) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | {24'h0, a});
  endfunction

  always @(posedge clk) begin
    mem_rd_data   <= mem_rd_en ? mem_word(mem_rd_addr) : POISON;
    mem_s1_b      <= mem_rd_en_b ? mem_word(mem_rd_addr_b) : POISON;
    mem_rd_data_b <= mem_s1_b;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [15:0] a, input logic [3:0] x,
                           input logic [3:0] y, input logic id);
    req_vld   = 1'b1;
    req_addr  = a;
    req_src_x = x;
    req_src_y = y;
    req_id    = id;
  endtask

  logic [31:0] held;
  int          k, seen, first, saw_rd;
  logic [31:0] first_data;
  logic        first_err;
  logic [3:0]  first_x;
  int          rsp_cyc [4];

  initial begin
    rst = 1'b1;
    req_vld = 1'b0; req_addr = '0; req_src_x = '0; req_src_y = '0; req_id = 1'b0;
    rsp_rdy = 1'b1;
    req_vld_b = 1'b0; req_addr_b = '0; req_src_x_b = '0; req_src_y_b = '0; req_id_b = 1'b0;
    rsp_rdy_b = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_val("rst_req_rdy", req_rdy, 1);
    check_val("rst_rsp_vld", rsp_vld, 0);
    check_val("rst_mem_rd_en", mem_rd_en, 0);
    check_val("rst_mem_rd_addr", mem_rd_addr, 0);
    check_val("rst_rsp_data", rsp_data, 0);
    check_val("rst_rsp_err", rsp_err, 0);
    check_val("rst_req_rdy_b", req_rdy_b, 1);

    // Single request: accepted cycle 0
    drive_req(16'h1105, 4'd2, 4'd3, 1'b1);
    tick();                                   // cycle 1
    req_vld = 1'b0;
    check_val("single_c1_rd_en", mem_rd_en, 0);
    tick();                                   // cycle 2
    check_val("single_c2_rd_en", mem_rd_en, 1);
    check_val("single_c2_rd_addr", mem_rd_addr, 8'd5);
    tick();                                   // cycle 3
    check_val("single_c3_rd_en", mem_rd_en, 0);
    check_val("single_c3_rsp_vld", rsp_vld, 0);
    tick();                                   // cycle 4
    check_val("single_c4_rsp_vld", rsp_vld, 1);
    check_val("single_data", rsp_data, 32'hDEAD_BEEF);
    check_val("single_dst_x", rsp_dst_x, 2);
    check_val("single_dst_y", rsp_dst_y, 3);
    check_val("single_id", rsp_id, 1);
    check_val("single_err", rsp_err, 0);
    tick();
    check_val("single_done_vld", rsp_vld, 0);

    // Backpressure: 6 offered, 5 accepted
    rsp_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_req(16'h1110 + 16'(i), 4'(i), 4'(15 - i), i[0]);
      check_val($sformatf("bp_req_rdy_%0d", i), req_rdy, (i < 5));
      tick();
    end
    req_vld = 1'b0;
    repeat (4) tick();
    check_val("bp_stall_vld", rsp_vld, 1);
    check_val("bp_stall_data", rsp_data, 32'hC0DE_0010);
    held = rsp_data;
    repeat (3) tick();
    check_val("bp_stall_held", rsp_data, held);
    check_val("bp_stall_dst_x", rsp_dst_x, 0);
    check_val("bp_stall_vld2", rsp_vld, 1);
    rsp_rdy = 1'b1;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_vld) begin
        if (k < 5) begin
          check_val($sformatf("bp_data_%0d", k), rsp_data, 32'hC0DE_0010 + 32'(k));
          check_val($sformatf("bp_dst_x_%0d", k), rsp_dst_x, k);
          check_val($sformatf("bp_dst_y_%0d", k), rsp_dst_y, 15 - k);
          check_val($sformatf("bp_id_%0d", k), rsp_id, k % 2);
        end
        k++;
      end
      tick();
    end
    check_val("bp_rsp_count", k, 5);

    // Asynchronous reset during the read strobe
    drive_req(16'h1106, 4'd4, 4'd4, 1'b0);
    tick();
    req_vld = 1'b0;
    tick();                                   // cycle 2 (read strobe)
    check_val("rst_rd_pre_en", mem_rd_en, 1);
    #3 rst = 1'b1;
    #1;
    check_val("rst_async_rd_en", mem_rd_en, 0);
    check_val("rst_async_rsp_vld", rsp_vld, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check_val("rst_rd_req_rdy", req_rdy, 1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_vld || mem_rd_en) seen++;
      tick();
    end
    check_val("rst_rd_no_activity", seen, 0);

    // Reset while waiting for read data
    drive_req(16'h1108, 4'd5, 4'd6, 1'b1);
    tick();
    req_vld = 1'b0;
    tick(); tick();                           // cycle 3 (waiting, data on bus)
    check_val("rst_wait_pre_data", mem_rd_data, 32'hC0DE_0008);
    #3 rst = 1'b1;
    #1;
    check_val("rst_wait_rsp_vld", rsp_vld, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_vld) seen++;
      tick();
    end
    check_val("rst_wait_no_rsp", seen, 0);
    drive_req(16'h1107, 4'd1, 4'd2, 1'b0);
    tick();
    req_vld = 1'b0;
    tick(); tick(); tick();                   // cycle 4
    check_val("post_rst_vld", rsp_vld, 1);
    check_val("post_rst_data", rsp_data, 32'hC0DE_0007);
    check_val("post_rst_dst_x", rsp_dst_x, 1);
    check_val("post_rst_dst_y", rsp_dst_y, 2);
    tick();

    // Request addressed to tile (0,2) arriving at tile (1,1)
    drive_req(16'h0209, 4'd3, 4'd1, 1'b0);
    tick();                                   // cycle 1
    req_vld = 1'b0;
    first = -1; saw_rd = 0;
    first_data = '0; first_err = 1'b0; first_x = '0;
    for (int c = 1; c < 9; c++) begin
      if (mem_rd_en) saw_rd = 1;
      if (rsp_vld && first < 0) begin
        first      = c;
        first_data = rsp_data;
        first_err  = rsp_err;
        first_x    = rsp_dst_x;
      end
      tick();
    end
    check_val("addr_dst_x", first_x, 3);
`ifdef FETCH_RESP_ADDR_CHECK_EN
    check_val("addr_saw_rd", saw_rd, 0);
    check_val("addr_rsp_cycle", first, 2);
    check_val("addr_data", first_data, 0);
    check_val("addr_err", first_err, 1);
`else
    check_val("addr_saw_rd", saw_rd, 1);
    check_val("addr_rsp_cycle", first, 4);
    check_val("addr_data", first_data, 32'hC0DE_0009);
    check_val("addr_err", first_err, 0);
`endif

    // Throughput with MEM_LATENCY=2: responses every 4 cycles
    k = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 4) begin
        req_vld_b   = 1'b1;
        req_addr_b  = 16'h1120 + 16'(c);
        req_src_x_b = 4'(c);
        req_src_y_b = 4'(c + 1);
        req_id_b    = c[0];
      end else begin
        req_vld_b = 1'b0;
      end
      if (rsp_vld_b) begin
        if (k < 4) begin
          rsp_cyc[k] = c;
          check_val($sformatf("tp_data_%0d", k), rsp_data_b, 32'hC0DE_0020 + 32'(k));
          check_val($sformatf("tp_dst_y_%0d", k), rsp_dst_y_b, k + 1);
        end
        k++;
      end
      tick();
    end
    check_val("tp_count", k, 4);
    if (k >= 4) begin
      check_val("tp_first_latency", rsp_cyc[0], 5);
      for (int j = 1; j < 4; j++)
        check_val($sformatf("tp_gap_%0d", j), rsp_cyc[j] - rsp_cyc[j-1], 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
